// File: rtl/inertial_sensor_reader.sv
// Configures the 6-axis inertial sensor over the SPI monarch, then reads
// pitch rate and Z accel on each data-ready interrupt.
module inertial_sensor_reader #(
    parameter int TMR_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    typedef enum logic [3:0] {
        INIT_WAIT,
        INIT1,
        INIT2,
        INIT3,
        INIT4,
        IDLE,
        RD_PL,
        RD_PH,
        RD_AZL,
        RD_AZH
    } state_t;

    state_t state, nxt_state;

    logic [TMR_BITS-1:0] timer;
    logic int_ff1, int_ff2;
    logic [7:0] pl, ph, azl, azh;

    logic        wrt_nxt;
    logic [15:0] cmd_nxt;
    logic        vld_nxt;
    logic        ld_pl, ld_ph, ld_azl, ld_azh;

    // Upper read byte carries no sensor data.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT_WAIT;
            timer   <= '0;
            int_ff1 <= 1'b0;
            int_ff2 <= 1'b0;
            wrt     <= 1'b0;
            cmd     <= 16'h0000;
            vld     <= 1'b0;
            pl      <= 8'h00;
            ph      <= 8'h00;
            azl     <= 8'h00;
            azh     <= 8'h00;
        end else begin
            state   <= nxt_state;
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
            wrt     <= wrt_nxt;
            cmd     <= cmd_nxt;
            vld     <= vld_nxt;
            if (state == INIT_WAIT)
                timer <= timer + 1'b1;
            if (ld_pl)
                pl <= rd_data[7:0];
            if (ld_ph)
                ph <= rd_data[7:0];
            if (ld_azl)
                azl <= rd_data[7:0];
            if (ld_azh)
                azh <= rd_data[7:0];
        end
    end

    always_comb begin
        nxt_state = state;
        wrt_nxt   = 1'b0;
        cmd_nxt   = cmd;
        vld_nxt   = 1'b0;
        ld_pl     = 1'b0;
        ld_ph     = 1'b0;
        ld_azl    = 1'b0;
        ld_azh    = 1'b0;
        unique case (state)
            INIT_WAIT: if (timer == '1) begin
                wrt_nxt   = 1'b1;
                cmd_nxt   = 16'h0D02;
                nxt_state = INIT1;
            end
            INIT1: if (done) begin
                wrt_nxt   = 1'b1;
                cmd_nxt   = 16'h1053;
                nxt_state = INIT2;
            end
            INIT2: if (done) begin
                wrt_nxt   = 1'b1;
                cmd_nxt   = 16'h1150;
                nxt_state = INIT3;
            end
            INIT3: if (done) begin
                wrt_nxt   = 1'b1;
                cmd_nxt   = 16'h1460;
                nxt_state = INIT4;
            end
            INIT4: if (done)
                nxt_state = IDLE;
            IDLE: if (int_ff2) begin
                wrt_nxt   = 1'b1;
                cmd_nxt   = 16'hA200;
                nxt_state = RD_PL;
            end
            RD_PL: if (done) begin
                ld_pl     = 1'b1;
                wrt_nxt   = 1'b1;
                cmd_nxt   = 16'hA300;
                nxt_state = RD_PH;
            end
            RD_PH: if (done) begin
                ld_ph     = 1'b1;
                wrt_nxt   = 1'b1;
                cmd_nxt   = 16'hAC00;
                nxt_state = RD_AZL;
            end
            RD_AZL: if (done) begin
                ld_azl    = 1'b1;
                wrt_nxt   = 1'b1;
                cmd_nxt   = 16'hAD00;
                nxt_state = RD_AZH;
            end
            // vld registers on the same edge as the last byte, so the
            // outputs are already complete while vld is high.
            RD_AZH: if (done) begin
                ld_azh    = 1'b1;
                vld_nxt   = 1'b1;
                nxt_state = IDLE;
            end
            default: nxt_state = INIT_WAIT;
        endcase
    end

    assign ptch_rt = {ph, pl};
    assign AZ      = {azh, azl};

endmodule

// File: tb/tb_inertial_sensor_reader.sv
// Bench for inertial_sensor_reader: SPI monarch responder model, command
// and sample scoreboards, table-driven sample sets plus corner sequences.
module tb_inertial_sensor_reader;

    logic        clk;
    logic        rst_n;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    logic done_auto;
    logic done_man;
    assign done = done_auto | done_man;

    inertial_sensor_reader #(.TMR_BITS(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .INT(INT),
        .done(done),
        .rd_data(rd_data),
        .wrt(wrt),
        .cmd(cmd),
        .vld(vld),
        .ptch_rt(ptch_rt),
        .AZ(AZ)
    );

    typedef struct {
        logic [15:0] pl;
        logic [15:0] ph;
        logic [15:0] azl;
        logic [15:0] azh;
        logic [15:0] ep;
        logic [15:0] ea;
    } vec_t;

    vec_t tbl[3];

    logic [15:0] expq[$];
    logic [15:0] rdq[$];
    logic [31:0] sampq[$];

    int checks = 0;
    int errors = 0;
    int wrt_cnt = 0;
    int vld_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // SPI monarch model: done 10 clocks after each wrt, read data from rdq.
    int cnt = 0;
    bit pend_rd = 0;
    initial begin
        done_auto = 1'b0;
        rd_data = 16'h0000;
    end
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt = 0;
            done_auto = 1'b0;
        end else begin
            done_auto = 1'b0;
            if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    done_auto = 1'b1;
                    if (pend_rd && rdq.size() != 0)
                        rd_data = rdq.pop_front();
                    else
                        rd_data = 16'h0000;
                end
            end
            if (wrt) begin
                cnt = 10;
                pend_rd = cmd[15];
            end
        end
    end

    // Output monitor / scoreboard.
    logic prev_vld = 1'b0;
    int stab = 0;
    logic [15:0] last_p, last_a;
    always @(negedge clk) begin
        if (wrt) begin
            wrt_cnt++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wrt_extra: got cmd %h expected no wrt", cmd);
            end else begin
                chk("cmd", {16'h0, cmd}, {16'h0, expq.pop_front()});
            end
        end
        if (vld) begin
            vld_cnt++;
            chk("vld_pulse", {31'h0, prev_vld}, 32'h0);
            if (sampq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL vld_extra: got %h/%h expected no vld",
                         ptch_rt, AZ);
            end else begin
                chk("sample", {ptch_rt, AZ}, sampq.pop_front());
            end
            last_p = ptch_rt;
            last_a = AZ;
            stab = 5;
        end else if (stab > 0) begin
            stab--;
            chk("hold", {ptch_rt, AZ}, {last_p, last_a});
        end
        prev_vld = vld;
    end

    task automatic wait_cmd(input logic [15:0] c, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (wrt && cmd == c)
                break;
        end
        if (i == limit) begin
            checks++;
            errors++;
            $display("FAIL wait_cmd: got timeout expected cmd %h", c);
        end
    endtask

    task automatic wait_vld(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (vld)
                break;
        end
        if (i == limit) begin
            checks++;
            errors++;
            $display("FAIL wait_vld: got timeout expected vld");
        end
    endtask

    task automatic push_init();
        expq.push_back(16'h0D02);
        expq.push_back(16'h1053);
        expq.push_back(16'h1150);
        expq.push_back(16'h1460);
    endtask

    task automatic push_set(input int i);
        expq.push_back(16'hA200);
        expq.push_back(16'hA300);
        expq.push_back(16'hAC00);
        expq.push_back(16'hAD00);
        rdq.push_back(tbl[i].pl);
        rdq.push_back(tbl[i].ph);
        rdq.push_back(tbl[i].azl);
        rdq.push_back(tbl[i].azh);
        sampq.push_back({tbl[i].ep, tbl[i].ea});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wrt"}, {31'h0, wrt}, 32'h0);
        chk({tag, "_vld"}, {31'h0, vld}, 32'h0);
        chk({tag, "_cmd"}, {16'h0, cmd}, 32'h0);
        chk({tag, "_ptch"}, {16'h0, ptch_rt}, 32'h0);
        chk({tag, "_az"}, {16'h0, AZ}, 32'h0);
    endtask

    task automatic release_and_time();
        int first;
        first = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (wrt) begin
                first = i;
                break;
            end
        end
        chk("first_wrt_edge", first, 16);
    endtask

    initial begin
        tbl[0] = '{16'hFF34, 16'hFF12, 16'hFFCD, 16'hFFAB,
                   16'h1234, 16'hABCD};
        tbl[1] = '{16'h0080, 16'h7F01, 16'h55FF, 16'hAA00,
                   16'h0180, 16'h00FF};
        tbl[2] = '{16'hA5FE, 16'h5AFF, 16'h1200, 16'h3480,
                   16'hFFFE, 16'h8000};

        rst_n = 1'b0;
        INT = 1'b0;
        done_man = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_zero("reset");

        // Power-up wait and init sequence; INT pulsed in INIT2.
        push_init();
        release_and_time();
        wait_cmd(16'h1053, 40);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        wait_cmd(16'h1460, 40);
        repeat (40) @(negedge clk);
        chk("init_wrt_cnt", wrt_cnt, 4);
        chk("init_vld_cnt", vld_cnt, 0);

        // Stray done in IDLE.
        done_man = 1'b1;
        @(negedge clk);
        done_man = 1'b0;
        repeat (20) @(negedge clk);
        chk("stray_wrt_cnt", wrt_cnt, 4);
        chk("stray_vld_cnt", vld_cnt, 0);
        chk("stray_ptch", {16'h0, ptch_rt}, 32'h0);

        // Single sample set.
        push_set(0);
        INT = 1'b1;
        wait_cmd(16'hA200, 20);
        INT = 1'b0;
        wait_vld(80);
        chk("s0_ptch", {16'h0, ptch_rt}, {16'h0, tbl[0].ep});
        chk("s0_az", {16'h0, AZ}, {16'h0, tbl[0].ea});
        repeat (10) @(negedge clk);

        // Two back-to-back sets with INT held high.
        push_set(1);
        push_set(2);
        INT = 1'b1;
        wait_cmd(16'hA200, 20);
        wait_vld(80);
        @(negedge clk);
        chk("b2b_wrt", {15'h0, wrt, cmd}, {16'h1, 16'hA200});
        INT = 1'b0;
        wait_vld(80);
        repeat (30) @(negedge clk);
        chk("read_wrt_cnt", wrt_cnt, 16);
        chk("read_vld_cnt", vld_cnt, 3);

        // Reset asserted while in RD_AZL.
        push_set(0);
        INT = 1'b1;
        wait_cmd(16'hA200, 20);
        INT = 1'b0;
        wait_cmd(16'hAC00, 40);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1 check_zero("midrst");
        expq.delete();
        rdq.delete();
        sampq.delete();
        wrt_cnt = 0;
        vld_cnt = 0;
        repeat (3) @(negedge clk);
        push_init();
        release_and_time();
        wait_cmd(16'h1460, 40);
        repeat (40) @(negedge clk);
        chk("reinit_wrt_cnt", wrt_cnt, 4);
        chk("reinit_vld_cnt", vld_cnt, 0);

        chk("expq_empty", expq.size(), 0);
        chk("sampq_empty", sampq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
